div_signed_ctrl: RTL
====================

Name: div_signed_ctrl

Overview:
- Front-end/back-end controller wrapped around the unsigned shift-subtract divider (div_subshift).
- Accepts signed or unsigned operand pairs over a valid/ready handshake and converts them to magnitudes.
- Launches the divider with a one-cycle start pulse and waits for its done.
- Applies sign correction, handles divide-by-zero locally, and presents registered results over a valid/ready output handshake.

Parameters:
DATA_W, 32, operand/result width; must match the attached divider's DATA_W.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
in_valid  in  1  operand pair valid.
in_ready  out  1  controller can accept operands.
in_signed  in  1  1 = two's-complement operation; 0 = unsigned.
dividend  in  DATA_W  dividend.
divisor  in  DATA_W  divisor.
div_start  out  1  start pulse to divider.
div_dividend  out  DATA_W  dividend magnitude to divider.
div_divisor  out  DATA_W  divisor magnitude to divider.
div_done  in  1  divider done.
div_quotient  in  DATA_W  divider unsigned quotient.
div_remainder  in  DATA_W  divider unsigned remainder.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
quotient  out  DATA_W  final quotient.
remainder  out  DATA_W  final remainder.
div_by_zero  out  1  result came from a zero divisor.
overflow  out  1  signed most-negative / -1 case.

Behaviour:

Reset (rst=0 at clk edge):
- state=IDLE; out_valid=0, div_start=0.
- quotient=0, remainder=0, div_by_zero=0, overflow=0.
- div_dividend=0, div_divisor=0.
- in_ready=1 after reset (decoded from IDLE).
- Reset mid-operation aborts to IDLE and discards the result. The divider is reset by the same system reset.

States: IDLE, LAUNCH, WAIT, FIX, OUT.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready.

IDLE, on accept:
- Capture sign flags:
  - neg_q = in_signed & (dividend[MSB] ^ divisor[MSB])
  - neg_r = in_signed & dividend[MSB]
- Register magnitudes into div_dividend/div_divisor. Magnitude = two's-complement negate when in_signed and MSB set.
- Most-negative value negates to itself and is treated as unsigned 2^(DATA_W-1).
- If divisor==0: go to OUT directly; never pulse div_start.
  - quotient = all ones, remainder = original dividend, div_by_zero=1.
- Else go to LAUNCH.

LAUNCH:
- div_start=1 for exactly this cycle; operands held stable. Next state is WAIT.

WAIT:
- div_done is ignored in the first WAIT cycle (guards against stale done).
- Afterwards, remain in WAIT until div_done=1, then go to FIX.

FIX (one cycle):
- quotient = neg_q ? -div_quotient : div_quotient.
- remainder = neg_r ? -div_remainder : div_remainder. Negation is mod 2^DATA_W.
- overflow = in_signed & dividend==100..0 & divisor==all ones. The arithmetic naturally yields q=dividend, r=0.
- Next state is OUT.

OUT:
- out_valid=1; quotient, remainder and flags held stable while out_valid & !out_ready.
- On out_ready: out_valid=0, state=IDLE. Outputs keep their last value.
- No overlap: the next operand is accepted at the earliest on the cycle after the output handshake.

Latency, accept in cycle A:
- Normal: div_start in A+1; div_done seen in A+DATA_W+2; out_valid in A+DATA_W+4 (A+36 for DATA_W=32).
- Divide-by-zero: out_valid in A+1.

Other rules:
- div_start is never asserted outside LAUNCH.
- div_dividend and div_divisor are stable from LAUNCH until exit from WAIT.

Optional Feature:
DIV_SIGNED_EN:
- Defined: in_signed honoured as above; overflow flag functional.
- Undefined: in_signed ignored and treated as 0; no negation logic; neg_q = neg_r = 0; overflow tied to 0. Latency and all other behaviour unchanged.

Test Plan:
1. Unsigned 100/7, out_ready=1 -> q=14, r=2, flags 0. out_valid exactly 36 cycles after accept; div_start one cycle wide.
2. Signed -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE. Signed 100/-7 -> q=0xFFFFFFF2, r=2. Signed -100/-7 -> q=14, r=0xFFFFFFFE.
3. 1234/0, signed and unsigned -> q=0xFFFFFFFF, r=1234, div_by_zero=1, out_valid at A+1, div_start never asserted.
4. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, overflow=1. Unsigned same operands -> q=0, r=0x80000000, overflow=0.
5. Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. Back-to-back ops accepted only after the output handshake.
6. rst=0 asserted during WAIT -> next cycle in IDLE, out_valid=0, in_ready=1. A subsequent 50/5 returns q=10, r=0.

Source files
------------

// File: rtl/div_signed_ctrl.sv
// div_signed_ctrl: signed/unsigned front-end and back-end around the unsigned
// shift-subtract divider (div_subshift). Operands arrive as magnitudes plus
// captured sign flags; the result is sign-corrected and held until the
// consumer takes it. Divide-by-zero is answered locally.
//
// Build option: DIV_SIGNED_EN. When it is defined, in_signed selects two's-complement
// operation and the overflow flag works. When it is undefined, every operation is
// unsigned and overflow stays 0.
//
// state  | meaning
// IDLE   | ready for an operand pair
// LAUNCH | div_start high for this cycle, operands held
// WAIT   | waiting for div_done (first cycle ignores a stale done)
// FIX    | sign correction of divider outputs
// OUT    | result presented until out_ready
module div_signed_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_done,
   input  logic [DATA_W-1:0] div_quotient,
   input  logic [DATA_W-1:0] div_remainder,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero,
   output logic              overflow
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIX, OUT} state_t;

   state_t            state;
   logic              wait_first;
   logic              accept;
   logic              ovf_pend;
   logic [DATA_W-1:0] dvd_mag;
   logic [DATA_W-1:0] dvs_mag;
   logic [DATA_W-1:0] fix_q;
   logic [DATA_W-1:0] fix_r;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;

`ifdef DIV_SIGNED_EN
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   logic neg_q;
   logic neg_r;
   logic dvd_neg;
   logic dvs_neg;

   // Magnitudes of the incoming operands; the most-negative value negates to
   // itself, which the divider then sees as unsigned 2^(DATA_W-1).
   always_comb begin
      dvd_neg = in_signed & dividend[DATA_W-1];
      dvs_neg = in_signed & divisor[DATA_W-1];
      dvd_mag = dvd_neg ? -dividend : dividend;
      dvs_mag = dvs_neg ? -divisor : divisor;
      fix_q   = neg_q ? -div_quotient : div_quotient;
      fix_r   = neg_r ? -div_remainder : div_remainder;
   end

   // Sign flags and the overflow case are captured at accept, since the raw
   // operands are gone by the time the divider finishes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ovf_pend <= 1'b0;
      end else if (accept) begin
         neg_q    <= dvd_neg ^ dvs_neg;
         neg_r    <= dvd_neg;
         ovf_pend <= in_signed & (dividend == MOST_NEG) & (&divisor);
      end
   end
`else
   logic unused_in_signed;
   assign unused_in_signed = in_signed;
   assign ovf_pend         = 1'b0;

   // Unsigned-only build: operands and results pass straight through.
   always_comb begin
      dvd_mag = dividend;
      dvs_mag = divisor;
      fix_q   = div_quotient;
      fix_r   = div_remainder;
   end
`endif

   // Sequencing FSM with registered handshake, start pulse and result outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         wait_first   <= 1'b0;
         div_start    <= 1'b0;
         out_valid    <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         div_by_zero  <= 1'b0;
         overflow     <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  div_dividend <= dvd_mag;
                  div_divisor  <= dvs_mag;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     out_valid   <= 1'b1;
                     state       <= OUT;
                  end else begin
                     div_start <= 1'b1;
                     state     <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               wait_first <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (div_done) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quotient    <= fix_q;
               remainder   <= fix_r;
               div_by_zero <= 1'b0;
               overflow    <= ovf_pend;
               out_valid   <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
